// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the TPU job scheduler slice.
package tpu_pkg;
  localparam int CYC_W = 16;
  localparam int JOB_ID_W = 4;
  localparam int JOB_ADDR_W = 10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAUNCH = 2'd1,
    RUN = 2'd2,
    REPORT = 2'd3
  } state_t;
  typedef struct packed {
    logic [JOB_ID_W-1:0] id;
    logic [JOB_ADDR_W-1:0] a_base;
    logic [JOB_ADDR_W-1:0] b_base;
    logic [JOB_ADDR_W-1:0] c_base;
  } desc_t;
endpackage

// File: rtl/tpu_job_fifo.sv
// tpu_job_fifo: synchronous FIFO; caller guarantees no push when full, no pop when empty.
module tpu_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler: queues job descriptors and runs them one at a time on the systolic array.
module tpu_job_scheduler
  import tpu_pkg::*;
#(
  parameter int JOB_DEPTH = 4,
  parameter int ADDR_W = JOB_ADDR_W,
  parameter int ID_W = JOB_ID_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic job_valid,
  output logic job_ready,
  input  logic [ID_W-1:0] job_id,
  input  logic [ADDR_W-1:0] job_a_base,
  input  logic [ADDR_W-1:0] job_b_base,
  input  logic [ADDR_W-1:0] job_c_base,
  output logic tpu_start,
  input  logic tpu_done,
  output logic [ADDR_W-1:0] cfg_a_base,
  output logic [ADDR_W-1:0] cfg_b_base,
  output logic [ADDR_W-1:0] cfg_c_base,
  output logic cmp_valid,
  input  logic cmp_ready,
  output logic [ID_W-1:0] cmp_id,
  output logic [CYC_W-1:0] cmp_cycles,
  output logic busy,
  output logic err_stray_done
);
  state_t state, state_nx;
  desc_t in_d, out_d;
  logic full, empty, push, pop;
  logic [$clog2(JOB_DEPTH):0] count;
  assign in_d = '{id: job_id, a_base: job_a_base, b_base: job_b_base, c_base: job_c_base};
  assign job_ready = !full;
  assign push = job_valid && job_ready;
  assign pop = state == IDLE && !empty;
  assign busy = state != IDLE || count != '0;
  tpu_job_fifo #(.DEPTH(JOB_DEPTH), .W($bits(desc_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(in_d), .dout(out_d),
    .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     state_nx = tpu_done ? REPORT : RUN;
      default: state_nx = cmp_ready ? IDLE : REPORT;
    endcase
  end
  // cmp_id/cmp_cycles double as the active job's tag and run counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tpu_start <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_id <= '0;
      cmp_cycles <= '0;
      cfg_a_base <= '0;
      cfg_b_base <= '0;
      cfg_c_base <= '0;
      err_stray_done <= 1'b0;
    end else begin
      state <= state_nx;
      tpu_start <= pop;
      cmp_valid <= state_nx == REPORT;
      if (pop) begin
        cmp_id <= out_d.id;
        cmp_cycles <= '0;
        cfg_a_base <= out_d.a_base;
        cfg_b_base <= out_d.b_base;
        cfg_c_base <= out_d.c_base;
      end else if (state == RUN && cmp_cycles != '1) begin
        cmp_cycles <= cmp_cycles + 1'b1;
      end
      if (tpu_done && state != RUN) err_stray_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tpu_job_scheduler.sv
// tb_tpu_job_scheduler: directed self-checking bench for the job scheduler.
module tb_tpu_job_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic job_valid = 1'b0, job_ready;
  logic [3:0] job_id = '0;
  logic [9:0] job_a_base = '0, job_b_base = '0, job_c_base = '0;
  logic tpu_start, tpu_done = 1'b0;
  logic [9:0] cfg_a_base, cfg_b_base, cfg_c_base;
  logic cmp_valid, cmp_ready = 1'b1;
  logic [3:0] cmp_id;
  logic [15:0] cmp_cycles;
  logic busy, err_stray_done;
  int passed = 0, total = 0;

  tpu_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_id(job_id), .job_a_base(job_a_base), .job_b_base(job_b_base),
    .job_c_base(job_c_base), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_cycles(cmp_cycles), .busy(busy), .err_stray_done(err_stray_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] id, input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c);
    job_valid = 1'b1;
    job_id = id;
    job_a_base = a;
    job_b_base = b;
    job_c_base = c;
    step;
    job_valid = 1'b0;
  endtask

  initial begin
    step;
    step;
    chk("rst_start", 32'(tpu_start), 0);
    chk("rst_cmp_valid", 32'(cmp_valid), 0);
    chk("rst_cmp_id", 32'(cmp_id), 0);
    chk("rst_cmp_cycles", 32'(cmp_cycles), 0);
    chk("rst_cfg", {2'b0, cfg_a_base, cfg_b_base, cfg_c_base}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_stray_done), 0);
    chk("rst_job_ready", 32'(job_ready), 1);
    rst_n = 1'b1;
    step;

    // single job, done raised 40 cycles after start
    push_one(4'd3, 10'h010, 10'h020, 10'h030);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_no_start_yet", 32'(tpu_start), 0);
    step;
    chk("t1_start", 32'(tpu_start), 1);
    chk("t1_cfg_a", 32'(cfg_a_base), 32'h010);
    chk("t1_cfg_b", 32'(cfg_b_base), 32'h020);
    chk("t1_cfg_c", 32'(cfg_c_base), 32'h030);
    step;
    chk("t1_start_one_cycle", 32'(tpu_start), 0);
    repeat (39) step;
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    chk("t1_cmp_valid", 32'(cmp_valid), 1);
    chk("t1_cmp_id", 32'(cmp_id), 3);
    chk("t1_cmp_cycles", 32'(cmp_cycles), 40);
    step;
    chk("t1_cmp_taken", 32'(cmp_valid), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_cfg_hold", 32'(cfg_a_base), 32'h010);

    // five back-to-back pushes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) push_one(4'(i), 10'(12'h100 + i), 10'(12'h200 + i), 10'(12'h300 + i));
    chk("t2_full", 32'(job_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tpu_done = 1'b1;
      step;
      tpu_done = 1'b0;
      chk("t2_cmp_valid", 32'(cmp_valid), 1);
      chk("t2_cmp_id", 32'(cmp_id), i);
      chk("t2_cmp_cycles", 32'(cmp_cycles), i == 0 ? 3 : 1);
      chk("t2_cfg_a", 32'(cfg_a_base), 32'h100 + i);
      step;
      step;
      if (i == 0) chk("t2_ready_again", 32'(job_ready), 1);
      if (i < 4) begin
        chk("t2_next_start", 32'(tpu_start), 1);
        step;
      end else begin
        chk("t2_no_start", 32'(tpu_start), 0);
        chk("t2_drained", 32'(busy), 0);
      end
    end

    // completion backpressure with a second job queued
    cmp_ready = 1'b0;
    push_one(4'd7, 10'h070, 10'h071, 10'h072);
    push_one(4'd8, 10'h080, 10'h081, 10'h082);
    step;
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(cmp_valid), 1);
      chk("t3_hold_id", 32'(cmp_id), 7);
      chk("t3_hold_cycles", 32'(cmp_cycles), 1);
      chk("t3_hold_no_start", 32'(tpu_start), 0);
      step;
    end
    cmp_ready = 1'b1;
    step;
    chk("t3_taken", 32'(cmp_valid), 0);
    chk("t3_no_start_k1", 32'(tpu_start), 0);
    step;
    chk("t3_start_k2", 32'(tpu_start), 1);
    chk("t3_cfg_a", 32'(cfg_a_base), 32'h080);
    step;
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    chk("t3_cmp_id2", 32'(cmp_id), 8);
    step;

    // stray done while idle
    chk("t4_idle", 32'(busy), 0);
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    chk("t4_err", 32'(err_stray_done), 1);
    chk("t4_no_cmp", 32'(cmp_valid), 0);
    chk("t4_still_idle", 32'(busy), 0);
    push_one(4'd5, 10'h050, 10'h051, 10'h052);
    step;
    chk("t4_start", 32'(tpu_start), 1);
    step;
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    chk("t4_cmp_id", 32'(cmp_id), 5);
    chk("t4_err_sticky", 32'(err_stray_done), 1);
    step;

    // long run saturates the cycle counter
    push_one(4'd9, 10'h090, 10'h091, 10'h092);
    step;
    repeat (70000) step;
    tpu_done = 1'b1;
    step;
    tpu_done = 1'b0;
    chk("t5_cmp_id", 32'(cmp_id), 9);
    chk("t5_saturated", 32'(cmp_cycles), 32'hFFFF);
    step;

    // reset during RUN with two jobs queued
    push_one(4'd10, 10'h0A0, 10'h0A1, 10'h0A2);
    push_one(4'd11, 10'h0B0, 10'h0B1, 10'h0B2);
    push_one(4'd12, 10'h0C0, 10'h0C1, 10'h0C2);
    step;
    chk("t6_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_job_ready", 32'(job_ready), 1);
    chk("t6_err_cleared", 32'(err_stray_done), 0);
    chk("t6_cfg_cleared", 32'(cfg_a_base), 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t6_no_start", 32'(tpu_start), 0);
      chk("t6_no_cmp", 32'(cmp_valid), 0);
      chk("t6_stay_idle", 32'(busy), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
